// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the trap sequencer: FSM states, request kinds,
// trap codes, mcause values and machine CSR addresses.
package trap_ctrl_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // What was accepted in IDLE; decides strobe and redirect target
  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_TRAP = 2'd1,
    KIND_IRQ  = 2'd2,
    KIND_MRET = 2'd3
  } kind_t;

  // trap_req encoding (2'b11 is reserved and behaves like unimp)
  localparam logic [1:0] TRAP_NONE  = 2'b00;
  localparam logic [1:0] TRAP_ECALL = 2'b01;
  localparam logic [1:0] TRAP_UNIMP = 2'b10;

  // mcause values
  localparam logic [31:0] CAUSE_ECALL    = 32'd11;
  localparam logic [31:0] CAUSE_UNIMP    = 32'd2;
  localparam logic [31:0] CAUSE_MEXT_IRQ = 32'h8000_000B;

  // Machine CSR addresses this block interacts with
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE_BIT = 3;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Combinational priority encoder: synchronous traps beat mret, which beats
// an enabled external interrupt. Produces the accept flag, kind and cause.
module trap_prio_enc
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      trap_req,
  input  logic            mret_req,
  input  logic            ext_irq,
  input  logic            irq_en,
  output logic            accept,
  output kind_t           kind,
  output logic [XLEN-1:0] cause
);

  // Pick the highest-priority pending request and its mcause value
  always_comb begin
    accept = 1'b0;
    kind   = KIND_NONE;
    cause  = '0;
    if (trap_req != TRAP_NONE) begin
      accept = 1'b1;
      kind   = KIND_TRAP;
      cause  = (trap_req == TRAP_ECALL) ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_UNIMP);
    end else if (mret_req) begin
      accept = 1'b1;
      kind   = KIND_MRET;
    end else if (ext_irq && irq_en) begin
      accept = 1'b1;
      kind   = KIND_IRQ;
      cause  = XLEN'(CAUSE_MEXT_IRQ);
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: accepts a trap/mret/interrupt in IDLE, drains and flushes
// the pipeline, strobes the CSR trap write once, then redirects fetch.
//
// Handshake: redirect_valid is held with a stable target until the cycle
// redirect_ready is sampled high; that cycle completes the transfer and the
// block returns to IDLE. While DRAIN is active redirect_ready is ignored.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DRAIN_MAX = 15,
  parameter int CNT_W     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      trap_req,
  input  logic            mret_req,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] csr_mstatus,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            pipe_idle,
  input  logic            redirect_ready,
  output logic            req_ack,
  output logic            stall,
  output logic            flush,
  output logic            csr_trap_we,
  output logic [XLEN-1:0] csr_epc,
  output logic [XLEN-1:0] csr_cause,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            drain_timeout,
  output state_t          dbg_state
);

  state_t            state, state_next;
  kind_t             kind_q;
  logic [XLEN-1:0]   pc_q, cause_q;
  logic [CNT_W-1:0]  cnt_q, cnt_next;
  logic              set_timeout;

  logic              enc_accept;
  kind_t             enc_kind;
  logic [XLEN-1:0]   enc_cause;
  logic              accept_now;

  // Only MIE matters in mstatus; mtvec mode bits are ignored (direct mode)
  logic              unused_csr_bits;
  assign unused_csr_bits = ^{csr_mstatus[XLEN-1:MSTATUS_MIE_BIT+1],
                             csr_mstatus[MSTATUS_MIE_BIT-1:0], csr_mtvec[1:0]};

  trap_prio_enc #(.XLEN(XLEN)) u_prio (
    .trap_req (trap_req),
    .mret_req (mret_req),
    .ext_irq  (ext_irq),
    .irq_en   (csr_mstatus[MSTATUS_MIE_BIT]),
    .accept   (enc_accept),
    .kind     (enc_kind),
    .cause    (enc_cause)
  );

  assign accept_now = (state == ST_IDLE) && enc_accept;
  assign dbg_state  = state;

  // State register plus the request snapshot taken at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      kind_q        <= KIND_NONE;
      pc_q          <= '0;
      cause_q       <= '0;
      cnt_q         <= '0;
      req_ack       <= 1'b0;
      drain_timeout <= 1'b0;
    end else begin
      state   <= state_next;
      cnt_q   <= cnt_next;
      req_ack <= accept_now;
      if (accept_now) begin
        kind_q  <= enc_kind;
        pc_q    <= trap_pc;
        cause_q <= enc_cause;
      end
      if (set_timeout) begin
        drain_timeout <= 1'b1;
      end
    end
  end

  // Next-state, drain counting and per-state control outputs
  always_comb begin
    state_next     = state;
    cnt_next       = cnt_q;
    set_timeout    = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    csr_trap_we    = 1'b0;
    redirect_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enc_accept) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end
      end
      ST_DRAIN: begin
        stall = 1'b1;
        flush = 1'b1;
        if (pipe_idle) begin
          state_next = ST_COMMIT;
        end else begin
          cnt_next = cnt_q + CNT_W'(1);
          // Give up waiting once the drain budget is exhausted
          if (cnt_next == CNT_W'(DRAIN_MAX)) begin
            set_timeout = 1'b1;
            state_next  = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        stall       = 1'b1;
        csr_trap_we = (kind_q != KIND_MRET);
        state_next  = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // CSR write data is only driven alongside the strobe
  assign csr_epc   = csr_trap_we ? pc_q    : '0;
  assign csr_cause = csr_trap_we ? cause_q : '0;

  // Target follows the live CSR inputs so a COMMIT-cycle update is honoured
  assign redirect_pc = !redirect_valid      ? '0 :
                       (kind_q == KIND_MRET) ? csr_mepc :
                                               {csr_mtvec[XLEN-1:2], 2'b00};

endmodule
